alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_pkg.sv | 31 +++
 rtl/alu_pipe_mul.sv | 61 ++++++
 rtl/alu_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the alu_pipe block: opcode encodings (io_opcode[3:0]),
// the sequencing FSM state type and a multiply-opcode helper.
// No ports.
package alu_pipe_pkg;

    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_ADD   = 4'h0;
    localparam logic [OPW-1:0] OP_SUB   = 4'h1;
    localparam logic [OPW-1:0] OP_SLL   = 4'h2;
    localparam logic [OPW-1:0] OP_MUL   = 4'h3;
    localparam logic [OPW-1:0] OP_SLT   = 4'h4;
    localparam logic [OPW-1:0] OP_SLTU  = 4'h6;
    localparam logic [OPW-1:0] OP_MULHU = 4'h7;
    localparam logic [OPW-1:0] OP_XOR   = 4'h8;
    localparam logic [OPW-1:0] OP_SRL   = 4'hA;
    localparam logic [OPW-1:0] OP_SRA   = 4'hB;
    localparam logic [OPW-1:0] OP_OR    = 4'hC;
    localparam logic [OPW-1:0] OP_AND   = 4'hE;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // True for the two opcodes served by the iterative multiplier.
    function automatic logic is_mul_op(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// Ports:
//   clock, reset  - clock and asynchronous active-high reset
//   start         - load a/b and begin; ignored bits while busy are not sampled
//   a, b          - multiplicand and multiplier (XLEN bits each)
//   done          - one-cycle pulse, product valid while high
//   product       - full 2*XLEN-bit unsigned product
module alu_pipe_mul #(
    parameter int unsigned XLEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic                done,
    output logic [2*XLEN-1:0]   product
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    logic            busy;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN:0]   sum_c;

    // Partial-product add; the carry becomes the new top bit after the right shift.
    assign sum_c   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    assign product = {acc_hi, acc_lo};

    // acc_lo starts as the multiplier and is consumed LSB-first as product bits shift in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy   <= 1'b1;
                count  <= '0;
                mcand  <= a;
                acc_hi <= '0;
                acc_lo <= b;
            end else if (busy) begin
                {acc_hi, acc_lo} <= {sum_c, acc_lo[XLEN-1:1]};
                count            <= count + CW'(1);
                if (count == CW'(XLEN - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Single-issue ALU with one registered output stage and valid/ready handshakes.
// Optional multiplier (MUL / MULHU) enabled by defining ALU_PIPE_MUL_EN.
// Ports:
//   clock, reset             - clock and asynchronous active-high reset
//   io_in_valid/io_in_ready  - operation offer / acceptance
//   io_a, io_b, io_opcode    - operands and opcode (only [3:0] decoded)
//   io_out_valid/io_out_ready- result offer / consumption
//   io_result, io_zero       - registered result and its zero flag
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic [XLEN-1:0] io_a,
    input  logic [XLEN-1:0] io_b,
    input  logic [5:0]      io_opcode,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [XLEN-1:0] io_result,
    output logic            io_zero
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [OPW-1:0]  op_c;
    logic [SHW-1:0]  shamt_c;
    logic            accept_c;
    logic            is_mul_c;
    logic            load_c;
    logic [XLEN-1:0] alu_c;
    logic [XLEN-1:0] load_val_c;
    logic            unused_opcode_c;

    assign op_c            = io_opcode[OPW-1:0];
    assign unused_opcode_c = ^io_opcode[5:4];
    assign shamt_c         = io_b[SHW-1:0];
    assign accept_c        = io_in_valid && io_in_ready;

    // Single-cycle datapath; unassigned opcodes (and multiply codes) give 0.
    always_comb begin
        alu_c = '0;
        case (op_c)
            OP_ADD:  alu_c = io_a + io_b;
            OP_SUB:  alu_c = io_a - io_b;
            OP_XOR:  alu_c = io_a ^ io_b;
            OP_OR:   alu_c = io_a | io_b;
            OP_AND:  alu_c = io_a & io_b;
            OP_SLL:  alu_c = io_a << shamt_c;
            OP_SRL:  alu_c = io_a >> shamt_c;
            OP_SRA:  alu_c = XLEN'($signed(io_a) >>> shamt_c);
            OP_SLT:  alu_c = XLEN'($signed(io_a) < $signed(io_b));
            OP_SLTU: alu_c = XLEN'(io_a < io_b);
            default: alu_c = '0;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    state_t            state;
    state_t            state_next;
    logic              mul_start_c;
    logic              mul_done;
    logic              hi_sel;
    logic [2*XLEN-1:0] mul_product;

    assign is_mul_c    = is_mul_op(op_c);
    assign io_in_ready = (state != MUL) && (!io_out_valid || io_out_ready);

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // MUL is left on the same edge the product is written to the output
    // register, so no new operation can collide with that write.
    always_comb begin
        state_next  = state;
        mul_start_c = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c && is_mul_c) begin
                    state_next  = MUL;
                    mul_start_c = 1'b1;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Remembers whether the running multiply returns the high half.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_sel <= 1'b0;
        end else if (mul_start_c) begin
            hi_sel <= (op_c == OP_MULHU);
        end
    end

    alu_pipe_mul #(
        .XLEN (XLEN)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start_c),
        .a       (io_a),
        .b       (io_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Output-stage load select: single-cycle result or finished product.
    always_comb begin
        load_c     = accept_c && !is_mul_c;
        load_val_c = alu_c;
        if ((state == MUL) && mul_done) begin
            load_c     = 1'b1;
            load_val_c = hi_sel ? mul_product[2*XLEN-1:XLEN] : mul_product[XLEN-1:0];
        end
    end
`else
    assign is_mul_c    = 1'b0;
    assign io_in_ready = !io_out_valid || io_out_ready;

    // Output-stage load select: single-cycle result only.
    always_comb begin
        load_c     = accept_c && !is_mul_c;
        load_val_c = alu_c;
    end
`endif

    // Output register: a load wins over a consume, so valid stays high back-to-back.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_out_valid <= 1'b0;
            io_result    <= '0;
            io_zero      <= 1'b0;
        end else if (load_c) begin
            io_out_valid <= 1'b1;
            io_result    <= load_val_c;
            io_zero      <= (load_val_c == '0);
        end else if (io_out_valid && io_out_ready) begin
            io_out_valid <= 1'b0;
        end
    end

endmodule
